hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter MAX_WAIT, default 15: max cycles MEM_WAIT may last before memory error.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 id_src_a, id_src_b  in  4 each  source registers of instruction in ID.
REQ-005 id_uses_a, id_uses_b  in  1 each  ID instruction reads src_a / src_b.
REQ-006 ex_dest  in  4  destination register of instruction in EX.
REQ-007 ex_mem_read, ex_regwrt  in  1 each  EX instruction is a load / writes a register.
REQ-008 branch_taken  in  4  per-condition taken flags from EX stage (zero, ~zero, carry, ~carry).
REQ-009 mem_req, mem_ready  in  1 each  MEM stage RAM access pending / RAM completes this cycle.
REQ-010 halt_in  in  1  halt request from decode.
REQ-011 pc_write, if_id_write  out  1 each  PC and IF/ID register enables.
REQ-012 pipe_en  out  1  enable for ID/EX, EX/MEM, MEM/WB registers.
REQ-013 id_ex_bubble, if_id_flush, id_ex_flush, pc_sel_branch  out  1 each  insert NOP into ID/EX; clear IF/ID; clear ID/EX; select branch target.
REQ-014 state  out  3  current FSM state (RUN=0, LOAD_STALL=1, FLUSH=2, MEM_WAIT=3, HALT=4).
REQ-015 mem_err  out  1  sticky memory-timeout flag.
REQ-016 stall_cnt  out  8  saturating count of cycles with pc_write=0.

Function
REQ-017 State register is the only sequential control; control outputs are combinational from state and current inputs.
REQ-018 Default (no condition): pc_write=if_id_write=pipe_en=1, all bubble/flush/sel outputs 0.
REQ-019 Priority per cycle, highest first: HALT state, memory wait, branch, load-use, halt_in.
REQ-020 Memory wait: mem_req=1 and mem_ready=0 in RUN/LOAD_STALL/FLUSH -> pc_write=if_id_write=pipe_en=0, no flush/bubble, next state MEM_WAIT, wait counter cleared to 1.
REQ-021 In MEM_WAIT: all enables 0; branch_taken and load-use ignored; wait counter increments each cycle mem_ready=0.
REQ-022 In MEM_WAIT with mem_ready=1 -> enables 1 that cycle, next state RUN; branch/load-use re-evaluated from the following cycle.
REQ-023 In MEM_WAIT, wait counter reaching MAX_WAIT with mem_ready=0 -> mem_err=1, next state HALT; mem_ready in that same cycle wins (RUN, no error).
REQ-024 Branch: any branch_taken bit =1 (RUN or LOAD_STALL, no memory wait) -> pc_sel_branch=if_id_flush=id_ex_flush=1, pc_write=1, next state FLUSH.
REQ-025 FLUSH lasts exactly one cycle; load-use detection masked; branch_taken still honoured (back-to-back flush allowed); next state RUN.
REQ-026 Load-use hazard: ex_mem_read & ex_regwrt & ((id_uses_a & id_src_a==ex_dest) | (id_uses_b & id_src_b==ex_dest)).
REQ-027 Load-use in RUN -> pc_write=if_id_write=0, id_ex_bubble=1, pipe_en=1, next state LOAD_STALL.
REQ-028 LOAD_STALL lasts exactly one cycle; detection masked; default outputs; next state RUN.
REQ-029 Branch and load-use in the same cycle -> branch wins, no bubble.
REQ-030 halt_in=1 in RUN with no higher-priority condition -> next state HALT.
REQ-031 HALT: pc_write=if_id_write=pipe_en=0; exits only by reset.
REQ-032 stall_cnt increments by 1 each cycle pc_write=0, saturates at 255, never wraps.

Reset
REQ-033 rst_n=0 at a rising edge -> state=RUN, wait counter=0, mem_err=0, stall_cnt=0, regardless of current state (including mid MEM_WAIT or HALT).
REQ-034 While rst_n=0 outputs reflect RUN state with inputs ignored: pc_write=if_id_write=pipe_en=1, all flush/bubble outputs 0.

Verification
REQ-035 EX load ex_dest=3, ID id_src_b=3, id_uses_b=1 -> one cycle pc_write=0, id_ex_bubble=1, state LOAD_STALL next, RUN after; stall_cnt=1.
REQ-036 branch_taken=4'b1000 together with load-use hazard -> pc_sel_branch=if_id_flush=id_ex_flush=1, id_ex_bubble=0, state FLUSH then RUN.
REQ-037 mem_req=1, mem_ready low 3 cycles then high -> pipe_en=0 for 3 cycles, 1 on ready cycle, state back to RUN, stall_cnt=3.
REQ-038 mem_req=1, mem_ready never high, MAX_WAIT=15 -> mem_err=1 and state HALT after 15 wait cycles; stays HALT until rst_n=0.
REQ-039 Hold pc_write=0 300 cycles (HALT) -> stall_cnt=255; rst_n=0 one edge -> stall_cnt=0, mem_err=0, state RUN.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stall, flush and memory-wait sequencing for a
// five-stage pipeline, with a sticky memory-timeout flag and stall counter.
module hazard_ctrl #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] id_src_a,
    input  logic [3:0] id_src_b,
    input  logic       id_uses_a,
    input  logic       id_uses_b,
    input  logic [3:0] ex_dest,
    input  logic       ex_mem_read,
    input  logic       ex_regwrt,
    input  logic [3:0] branch_taken,
    input  logic       mem_req,
    input  logic       mem_ready,
    input  logic       halt_in,
    output logic       pc_write,
    output logic       if_id_write,
    output logic       pipe_en,
    output logic       id_ex_bubble,
    output logic       if_id_flush,
    output logic       id_ex_flush,
    output logic       pc_sel_branch,
    output logic [2:0] state,
    output logic       mem_err,
    output logic [7:0] stall_cnt
);

    localparam int unsigned WCNT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WCNT_W-1:0] MAX_W = WCNT_W'(MAX_WAIT);

    typedef enum logic [2:0] {
        ST_RUN        = 3'd0,
        ST_LOAD_STALL = 3'd1,
        ST_FLUSH      = 3'd2,
        ST_MEM_WAIT   = 3'd3,
        ST_HALT       = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic              mem_err_q, mem_err_d;
    logic [7:0]        stall_cnt_q, stall_cnt_d;
    logic [WCNT_W-1:0] wcnt_inc;
    logic              load_use;

    assign wcnt_inc = wcnt_q + WCNT_W'(1);
    assign load_use = ex_mem_read & ex_regwrt &
                      ((id_uses_a & (id_src_a == ex_dest)) |
                       (id_uses_b & (id_src_b == ex_dest)));

    // Next-state and control outputs; while in reset the outputs look like RUN.
    always_comb begin
        state_d       = state_q;
        wcnt_d        = wcnt_q;
        mem_err_d     = mem_err_q;
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        pipe_en       = 1'b1;
        id_ex_bubble  = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        pc_sel_branch = 1'b0;
        if (rst_n) begin
            case (state_q)
                ST_HALT: begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    pipe_en     = 1'b0;
                end
                ST_MEM_WAIT: begin
                    if (mem_ready) begin
                        state_d = ST_RUN;
                    end else begin
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        pipe_en     = 1'b0;
                        wcnt_d      = wcnt_inc;
                        if (wcnt_inc >= MAX_W) begin
                            mem_err_d = 1'b1;
                            state_d   = ST_HALT;
                        end
                    end
                end
                default: begin
                    // RUN, LOAD_STALL and FLUSH share the priority chain;
                    // load-use and halt_in are only looked at from RUN.
                    if (mem_req && !mem_ready) begin
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        pipe_en     = 1'b0;
                        wcnt_d      = WCNT_W'(1);
                        state_d     = ST_MEM_WAIT;
                    end else if (|branch_taken) begin
                        pc_sel_branch = 1'b1;
                        if_id_flush   = 1'b1;
                        id_ex_flush   = 1'b1;
                        state_d       = ST_FLUSH;
                    end else if (state_q == ST_RUN && load_use) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_bubble = 1'b1;
                        state_d      = ST_LOAD_STALL;
                    end else if (state_q == ST_RUN && halt_in) begin
                        state_d = ST_HALT;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            endcase
        end

        stall_cnt_d = stall_cnt_q;
        if (!pc_write && stall_cnt_q != 8'hFF) begin
            stall_cnt_d = stall_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            wcnt_q      <= '0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            mem_err_q   <= mem_err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign state     = 3'(state_q);
    assign mem_err   = mem_err_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed scenarios followed by random
// traffic, checked against a rule-level reference model.
module tb_hazard_ctrl;

    localparam int MAX_WAIT = 15;
    localparam int M_RUN = 0, M_LS = 1, M_FLUSH = 2, M_MW = 3, M_HALT = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] id_src_a, id_src_b, ex_dest, branch_taken;
    logic       id_uses_a, id_uses_b, ex_mem_read, ex_regwrt;
    logic       mem_req, mem_ready, halt_in;
    logic       pc_write, if_id_write, pipe_en, id_ex_bubble;
    logic       if_id_flush, id_ex_flush, pc_sel_branch;
    logic [2:0] state;
    logic       mem_err;
    logic [7:0] stall_cnt;

    hazard_ctrl #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_src_a(id_src_a), .id_src_b(id_src_b),
        .id_uses_a(id_uses_a), .id_uses_b(id_uses_b),
        .ex_dest(ex_dest), .ex_mem_read(ex_mem_read), .ex_regwrt(ex_regwrt),
        .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .halt_in(halt_in),
        .pc_write(pc_write), .if_id_write(if_id_write), .pipe_en(pipe_en),
        .id_ex_bubble(id_ex_bubble), .if_id_flush(if_id_flush),
        .id_ex_flush(id_ex_flush), .pc_sel_branch(pc_sel_branch),
        .state(state), .mem_err(mem_err), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0] ctrl;   // pc_write, if_id_write, pipe_en, bubble, if_id_flush, id_ex_flush, sel
        logic [2:0] st;
        logic       err;
        logic [7:0] sc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model state
    int m_mode  = M_RUN;
    int m_waits = 0;
    int m_err   = 0;
    int m_stall = 0;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
        end
    endtask

    // Monitor: every cycle the DUT presents outputs, compare against the oldest expectation
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("ctrl", int'({pc_write, if_id_write, pipe_en, id_ex_bubble,
                              if_id_flush, id_ex_flush, pc_sel_branch}), int'(e.ctrl));
            chk("state", int'(state), int'(e.st));
            chk("mem_err", int'(mem_err), int'(e.err));
            chk("stall_cnt", int'(stall_cnt), int'(e.sc));
        end
    end

    // Apply current inputs for one cycle: predict, push, clock, advance the model.
    task automatic step();
        exp_t e;
        int pcw, ifw, pen, bub, flush, nmode, nwaits, nerr;
        bit hazard;
        pcw = 1; ifw = 1; pen = 1; bub = 0; flush = 0;
        nmode = m_mode; nwaits = m_waits; nerr = m_err;
        hazard = ex_mem_read && ex_regwrt &&
                 ((id_uses_a && id_src_a == ex_dest) || (id_uses_b && id_src_b == ex_dest));
        if (rst_n) begin
            if (m_mode == M_HALT) begin
                pcw = 0; ifw = 0; pen = 0;
            end else if (m_mode == M_MW) begin
                if (mem_ready) nmode = M_RUN;
                else begin
                    pcw = 0; ifw = 0; pen = 0;
                    nwaits = m_waits + 1;
                    if (nwaits >= MAX_WAIT) begin nerr = 1; nmode = M_HALT; end
                end
            end else if (mem_req && !mem_ready) begin
                pcw = 0; ifw = 0; pen = 0; nwaits = 1; nmode = M_MW;
            end else if (branch_taken != 4'd0) begin
                flush = 1; nmode = M_FLUSH;
            end else if (m_mode == M_RUN && hazard) begin
                pcw = 0; ifw = 0; bub = 1; nmode = M_LS;
            end else if (m_mode == M_RUN && halt_in) begin
                nmode = M_HALT;
            end else begin
                nmode = M_RUN;
            end
        end
        e.ctrl = {pcw[0], ifw[0], pen[0], bub[0], flush[0], flush[0], flush[0]};
        e.st   = 3'(m_mode);
        e.err  = m_err[0];
        e.sc   = 8'(m_stall);
        exp_q.push_back(e);
        @(posedge clk);
        if (!rst_n) begin
            m_mode = M_RUN; m_waits = 0; m_err = 0; m_stall = 0;
        end else begin
            if (pcw == 0 && m_stall < 255) m_stall = m_stall + 1;
            m_mode = nmode; m_waits = nwaits; m_err = nerr;
        end
        #1;
    endtask

    task automatic idle();
        rst_n = 1'b1;
        id_src_a = 4'd0; id_src_b = 4'd0; id_uses_a = 1'b0; id_uses_b = 1'b0;
        ex_dest = 4'd0; ex_mem_read = 1'b0; ex_regwrt = 1'b0; branch_taken = 4'd0;
        mem_req = 1'b0; mem_ready = 1'b0; halt_in = 1'b0;
    endtask

    task automatic set_hazard_b();
        ex_mem_read = 1'b1; ex_regwrt = 1'b1; ex_dest = 4'd3;
        id_src_b = 4'd3; id_uses_b = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        idle();
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        idle();

        // load-use on src_b
        set_hazard_b(); step(); idle(); step(); step();
        // branch with simultaneous load-use
        set_hazard_b(); branch_taken = 4'b1000; step(); idle(); step(); step();
        // back-to-back branches through FLUSH
        branch_taken = 4'b0001; repeat (3) step(); idle(); step();
        // branch arriving during LOAD_STALL
        set_hazard_b(); step(); idle(); branch_taken = 4'b0100; step(); idle(); step();
        // memory wait of three cycles
        mem_req = 1'b1; repeat (3) step(); mem_ready = 1'b1; step(); idle(); step();
        // ready arriving on the last allowed wait cycle wins
        mem_req = 1'b1; repeat (MAX_WAIT - 1) step(); mem_ready = 1'b1; step(); idle(); step();
        // timeout into HALT, then long HALT saturating the stall counter
        mem_req = 1'b1; repeat (MAX_WAIT + 5) step();
        idle(); set_hazard_b(); branch_taken = 4'b0010; repeat (300) step();
        do_reset(); step(); step();
        // halt request from RUN, then reset out of HALT
        halt_in = 1'b1; step(); idle(); repeat (4) step();
        do_reset(); step();
        // memory wait entered from FLUSH
        branch_taken = 4'b0001; step(); idle(); mem_req = 1'b1; step(); step();
        mem_ready = 1'b1; step(); idle(); step();

        // random traffic
        for (int i = 0; i < 2500; i++) begin
            rst_n        = ($urandom_range(0, 49) != 0);
            id_src_a     = 4'($urandom_range(0, 3));
            id_src_b     = 4'($urandom_range(0, 3));
            ex_dest      = 4'($urandom_range(0, 3));
            id_uses_a    = 1'($urandom_range(0, 1));
            id_uses_b    = 1'($urandom_range(0, 1));
            ex_mem_read  = 1'($urandom_range(0, 1));
            ex_regwrt    = ($urandom_range(0, 3) != 0);
            branch_taken = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            mem_req      = ($urandom_range(0, 3) == 0);
            mem_ready    = ($urandom_range(0, 2) == 0);
            halt_in      = ($urandom_range(0, 39) == 0);
            step();
        end
        idle();

        // bounded drain of the scoreboard
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
        chk("drain", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
